// File: rtl/ece571_regfile_mp.sv
// Multi-port register file: byte-enabled dual write (port 1 wins overlaps), NREAD reads, busy scoreboard.
// Reads are combinational (optional same-cycle write bypass); data, busy and wr_conflict update 1 edge later; never stalls.
module ece571_regfile_mp #(
  parameter int DW       = 32,
  parameter int DEPTH    = 16,
  parameter int AW       = $clog2(DEPTH),
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREAD*AW-1:0] rd_addr,
  output logic [NREAD*DW-1:0] rd_data,
  output logic [NREAD-1:0]    rd_busy,
  input  logic                we0,
  input  logic                we1,
  input  logic [AW-1:0]       wa0,
  input  logic [AW-1:0]       wa1,
  input  logic [DW/8-1:0]     wbe0,
  input  logic [DW/8-1:0]     wbe1,
  input  logic [DW-1:0]       wd0,
  input  logic [DW-1:0]       wd1,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic [DEPTH-1:0]    busy,
  output logic                wr_conflict
);
  localparam int NB = DW / 8;

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DW-1:0]    mem_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             wr_conflict_q;
  logic             wr_conflict_d;

  // Next stored value per register; port 1 is applied last so it wins overlapping bytes.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      mem_d[r] = mem_q[r];
      for (int k = 0; k < NB; k++) begin
        if (we0 && wbe0[k] && (wa0 == AW'(r))) mem_d[r][8*k +: 8] = wd0[8*k +: 8];
        if (we1 && wbe1[k] && (wa1 == AW'(r))) mem_d[r][8*k +: 8] = wd1[8*k +: 8];
      end
      if ((ZERO_REG != 0) && (r == 0)) mem_d[r] = '0;
    end
  end

  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      if (rsv_en && (rsv_addr == AW'(r))) begin
        busy_d[r] = 1'b1;
      end else if ((we0 && (wa0 == AW'(r))) || (we1 && (wa1 == AW'(r)))) begin
        busy_d[r] = 1'b0;
      end else begin
        busy_d[r] = busy_q[r];
      end
      if ((ZERO_REG != 0) && (r == 0)) busy_d[r] = 1'b0;
    end
  end

  always_comb begin
    wr_conflict_d = we0 && we1 && (wa0 == wa1) && (|(wbe0 & wbe1))
                    && !((ZERO_REG != 0) && (wa0 == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) mem_q[r] <= '0;
      busy_q        <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      for (int r = 0; r < DEPTH; r++) mem_q[r] <= mem_d[r];
      busy_q        <= busy_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  // Bypass is suppressed while in reset so outputs hold their cleared values.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NREAD; i++) begin
      if ((BYPASS != 0) && rst_n) rd_data[i*DW +: DW] = mem_d[rd_addr[i*AW +: AW]];
      else                        rd_data[i*DW +: DW] = mem_q[rd_addr[i*AW +: AW]];
      rd_busy[i] = busy_q[rd_addr[i*AW +: AW]];
    end
  end

  assign busy        = busy_q;
  assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_ece571_regfile_mp.sv
// Bench for ece571_regfile_mp: directed checks on a default instance, random traffic on a wide no-bypass instance.
module tb_ece571_regfile_mp;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        a_rst_n;
  logic [7:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic        a_we0, a_we1;
  logic [3:0]  a_wa0, a_wa1, a_wbe0, a_wbe1;
  logic [31:0] a_wd0, a_wd1;
  logic        a_rsv_en;
  logic [3:0]  a_rsv_addr;
  logic [15:0] a_busy;
  logic        a_wr_conflict;

  logic         b_rst_n;
  logic [19:0]  b_rd_addr;
  logic [255:0] b_rd_data;
  logic [3:0]   b_rd_busy;
  logic         b_we0, b_we1;
  logic [4:0]   b_wa0, b_wa1;
  logic [7:0]   b_wbe0, b_wbe1;
  logic [63:0]  b_wd0, b_wd1;
  logic         b_rsv_en;
  logic [4:0]   b_rsv_addr;
  logic [31:0]  b_busy;
  logic         b_wr_conflict;

  logic [63:0]  m_mem [32];
  logic [31:0]  m_busy;
  logic         m_conf;
  logic [255:0] exp_rd;
  logic [3:0]   exp_rb;
  logic [31:0]  set_mask, clr_mask;
  logic [4:0]   ra;

  ece571_regfile_mp #(.DW(32), .DEPTH(16), .NREAD(2), .ZERO_REG(1), .BYPASS(1)) u_a (
    .clk(clk), .rst_n(a_rst_n), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .we0(a_we0), .we1(a_we1), .wa0(a_wa0), .wa1(a_wa1), .wbe0(a_wbe0), .wbe1(a_wbe1),
    .wd0(a_wd0), .wd1(a_wd1), .rsv_en(a_rsv_en), .rsv_addr(a_rsv_addr),
    .busy(a_busy), .wr_conflict(a_wr_conflict)
  );

  ece571_regfile_mp #(.DW(64), .DEPTH(32), .NREAD(4), .ZERO_REG(1), .BYPASS(0)) u_b (
    .clk(clk), .rst_n(b_rst_n), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .we0(b_we0), .we1(b_we1), .wa0(b_wa0), .wa1(b_wa1), .wbe0(b_wbe0), .wbe1(b_wbe1),
    .wd0(b_wd0), .wd1(b_wd1), .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr),
    .busy(b_busy), .wr_conflict(b_wr_conflict)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_we0 = 1'b0; a_we1 = 1'b0; a_wa0 = '0; a_wa1 = '0; a_wbe0 = '0; a_wbe1 = '0;
    a_wd0 = '0; a_wd1 = '0; a_rsv_en = 1'b0; a_rsv_addr = '0;
  endtask

  task automatic a_rand();
    a_we0 = 1'($urandom); a_we1 = 1'($urandom); a_wa0 = 4'($urandom); a_wa1 = 4'($urandom);
    a_wbe0 = 4'($urandom); a_wbe1 = 4'($urandom); a_wd0 = $urandom; a_wd1 = $urandom;
    a_rsv_en = 1'($urandom); a_rsv_addr = 4'($urandom); a_rd_addr = 8'($urandom);
  endtask

  task automatic b_idle();
    b_we0 = 1'b0; b_we1 = 1'b0; b_wa0 = '0; b_wa1 = '0; b_wbe0 = '0; b_wbe1 = '0;
    b_wd0 = '0; b_wd1 = '0; b_rsv_en = 1'b0; b_rsv_addr = '0; b_rd_addr = '0;
  endtask

  initial begin
    a_rst_n = 1'b0;
    b_rst_n = 1'b0;
    a_idle();
    b_idle();
    a_rd_addr = '0;

    // Reset held with random traffic on the inputs
    repeat (3) begin
      a_rand();
      tick();
    end
    a_rand();
    #1;
    chk("rst_rd_data", a_rd_data, 0);
    chk("rst_rd_busy", a_rd_busy, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_conflict", a_wr_conflict, 0);
    a_idle();
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    a_rd_addr = {4'd9, 4'd5};
    #1;
    chk("post_rst_rd_data", a_rd_data, 0);
    chk("post_rst_busy", a_busy, 0);

    // Register 0 ignores writes, including the bypass path
    a_we0 = 1'b1; a_wa0 = 4'd0; a_wd0 = 32'hDEADBEEF; a_wbe0 = 4'hF;
    a_rd_addr = {4'd0, 4'd0};
    #1;
    chk("r0_bypass", a_rd_data, 0);
    tick();
    a_idle();
    #1;
    chk("r0_stored", a_rd_data, 0);

    // Byte-enable merge with port 1 priority
    a_we0 = 1'b1; a_wa0 = 4'd5; a_wd0 = 32'h11223344; a_wbe0 = 4'hF;
    tick();
    a_we0 = 1'b1; a_wa0 = 4'd5; a_wd0 = 32'hAAAAAAAA; a_wbe0 = 4'h3;
    a_we1 = 1'b1; a_wa1 = 4'd5; a_wd1 = 32'hBBBBBBBB; a_wbe1 = 4'h6;
    a_rd_addr = {4'd0, 4'd5};
    #1;
    chk("merge_bypass", a_rd_data[31:0], 32'h11BBBBAA);
    chk("conflict_before", a_wr_conflict, 0);
    tick();
    a_idle();
    #1;
    chk("merge_stored", a_rd_data[31:0], 32'h11BBBBAA);
    chk("conflict_pulse", a_wr_conflict, 1);
    tick();
    chk("conflict_cleared", a_wr_conflict, 0);

    // Same-cycle bypass on both read ports
    a_we0 = 1'b1; a_wa0 = 4'd3; a_wd0 = 32'h0000CAFE; a_wbe0 = 4'hF;
    a_rd_addr = {4'd3, 4'd3};
    #1;
    chk("bypass_same_cycle", a_rd_data, {32'h0000CAFE, 32'h0000CAFE});
    tick();
    a_idle();

    // Scoreboard: reserve, then write clears; reserve beats a same-cycle write
    a_rsv_en = 1'b1; a_rsv_addr = 4'd7; a_rd_addr = {4'd7, 4'd0};
    #1;
    chk("rsv_no_bypass", a_rd_busy, 2'b00);
    tick();
    a_idle();
    a_we0 = 1'b1; a_wa0 = 4'd7; a_wbe0 = 4'h0; a_wd0 = $urandom;
    #1;
    chk("busy7_set", a_busy, 16'h0080);
    chk("rd_busy7_set", a_rd_busy, 2'b10);
    tick();
    a_idle();
    #1;
    chk("busy7_cleared", a_busy[7], 0);
    chk("wbe_zero_no_write", a_rd_data[63:32], 0);
    a_rsv_en = 1'b1; a_rsv_addr = 4'd7;
    a_we1 = 1'b1; a_wa1 = 4'd7; a_wbe1 = 4'hF; a_wd1 = $urandom;
    tick();
    a_idle();
    #1;
    chk("rsv_beats_write", a_busy, 16'h0080);

    // Register 0 is never busy and never flags a conflict
    a_rsv_en = 1'b1; a_rsv_addr = 4'd0;
    a_we0 = 1'b1; a_wa0 = 4'd0; a_wbe0 = 4'hF; a_wd0 = $urandom;
    a_we1 = 1'b1; a_wa1 = 4'd0; a_wbe1 = 4'hF; a_wd1 = $urandom;
    tick();
    a_idle();
    #1;
    chk("r0_never_busy", a_busy, 16'h0080);
    chk("r0_no_conflict", a_wr_conflict, 0);

    // Asynchronous reset between edges with traffic active
    a_we0 = 1'b1; a_wa0 = 4'd5; a_wbe0 = 4'hF; a_wd0 = 32'h55667788;
    a_we1 = 1'b1; a_wa1 = 4'd5; a_wbe1 = 4'h1; a_wd1 = 32'h000000EE;
    a_rsv_en = 1'b1; a_rsv_addr = 4'd9;
    tick();
    #2;
    a_rst_n = 1'b0;
    #1;
    chk("async_busy", a_busy, 0);
    chk("async_conflict", a_wr_conflict, 0);
    chk("async_rd_data", a_rd_data, 0);
    a_idle();
    a_rst_n = 1'b1;
    a_rd_addr = {4'd3, 4'd5};
    #1;
    chk("async_regs_cleared", a_rd_data, 0);
    a_we0 = 1'b1; a_wa0 = 4'd9; a_wbe0 = 4'hF; a_wd0 = 32'h12345678;
    tick();
    a_idle();
    a_rd_addr = {4'd9, 4'd9};
    #1;
    chk("resume_write", a_rd_data, {32'h12345678, 32'h12345678});

    // No-bypass instance: old value in the write cycle, new value next cycle
    b_we0 = 1'b1; b_wa0 = 5'd3; b_wd0 = 64'h0000CAFE; b_wbe0 = 8'hFF;
    b_rd_addr = {5'd0, 5'd0, 5'd0, 5'd3};
    #1;
    chk("nobypass_old", b_rd_data[63:0], 0);
    tick();
    b_we0 = 1'b0;
    #1;
    chk("nobypass_new", b_rd_data[63:0], 64'h0000CAFE);

    // Random traffic against a vector-level reference model
    b_idle();
    b_rst_n = 1'b0;
    #1;
    b_rst_n = 1'b1;
    for (int r = 0; r < 32; r++) m_mem[r] = '0;
    m_busy = '0;
    m_conf = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      b_we0 = 1'($urandom); b_we1 = 1'($urandom);
      b_wa0 = 5'($urandom);
      b_wa1 = ($urandom_range(0, 2) == 0) ? b_wa0 : 5'($urandom);
      b_wbe0 = 8'($urandom); b_wbe1 = 8'($urandom);
      b_wd0 = {$urandom, $urandom}; b_wd1 = {$urandom, $urandom};
      b_rsv_en = ($urandom_range(0, 3) == 0);
      b_rsv_addr = ($urandom_range(0, 3) == 0) ? b_wa0 : 5'($urandom);
      b_rd_addr = 20'($urandom);
      #1;
      for (int i = 0; i < 4; i++) begin
        ra = b_rd_addr[i*5 +: 5];
        exp_rd[i*64 +: 64] = m_mem[ra];
        exp_rb[i] = m_busy[ra];
      end
      chk("rand_rd_data", b_rd_data, exp_rd);
      chk("rand_rd_busy", b_rd_busy, exp_rb);
      chk("rand_busy", b_busy, m_busy);
      chk("rand_conflict", b_wr_conflict, m_conf);
      set_mask = b_rsv_en ? (32'd1 << b_rsv_addr) : 32'd0;
      clr_mask = (b_we0 ? (32'd1 << b_wa0) : 32'd0) | (b_we1 ? (32'd1 << b_wa1) : 32'd0);
      m_busy = ((m_busy & ~clr_mask) | set_mask) & ~32'd1;
      m_conf = b_we0 && b_we1 && (b_wa0 == b_wa1) && ((b_wbe0 & b_wbe1) != 0) && (b_wa0 != 0);
      for (int k = 0; k < 8; k++) if (b_we0 && b_wbe0[k]) m_mem[b_wa0][8*k +: 8] = b_wd0[8*k +: 8];
      for (int k = 0; k < 8; k++) if (b_we1 && b_wbe1[k]) m_mem[b_wa1][8*k +: 8] = b_wd1[8*k +: 8];
      m_mem[0] = '0;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
